// File: rtl/uart_tx_controller_pkg.sv
// Shared definitions for the control sequencer, UART receiver and UART transmitter.
// Holds the sequencer phase codes, the UART frame constants and the transmit FSM states.
package uart_tx_controller_pkg;

  localparam logic [1:0] ST_RECEIVE  = 2'b00;
  localparam logic [1:0] ST_PROCESS  = 2'b01;
  localparam logic [1:0] ST_TRANSMIT = 2'b10;
  localparam logic [1:0] ST_ALLDONE  = 2'b11;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } tx_state_e;

endpackage

// File: rtl/uart_tx_controller_if.sv
// Sequencer, data-memory and serial-line signals of the transmit engine.
// The slave modport is the engine's view; the master modport is its environment's.
interface uart_tx_controller_if
  import uart_tx_controller_pkg::*;
#(
  parameter int ADDR_W = 16
);

  logic [1:0]           status;
  logic [DATA_BITS-1:0] mem_rdata;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_re;
  logic                 tx;
  logic                 busy;
  logic                 end_transmitting;

  modport master (
    output status, mem_rdata,
    input  mem_addr, mem_re, tx, busy, end_transmitting
  );

  modport slave (
    input  status, mem_rdata,
    output mem_addr, mem_re, tx, busy, end_transmitting
  );

endinterface

// File: rtl/uart_tx_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and pulses bit_tick on the last count of each bit.
// restart forces the count back to 0 so every FSM state begins on a full bit period.
module uart_tx_baud_gen
  import uart_tx_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = (cnt == LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_controller.sv
// Transmit-phase engine: once armed by the sequencer, reads NUM_BYTES bytes from data
// memory in address order, sends each as an 8N1 frame, then raises a sticky completion flag.
module uart_tx_controller
  import uart_tx_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int ADDR_W       = 16,
  parameter int NUM_BYTES    = 65536
) (
  input logic                 clk,
  input logic                 rst,
  uart_tx_controller_if.slave bus
);

  // One extra bit lets NUM_BYTES = 2^ADDR_W be counted without wrapping.
  localparam int                BYTE_W    = ADDR_W + 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam int                BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  tx_state_e            state, state_n;
  logic [BYTE_W-1:0]    byte_cnt, byte_cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 tx_q, tx_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;
  logic                 bit_tick;
  logic                 restart;

  uart_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_tick(bit_tick)
  );

  // The baud counter is parked while waiting and cleared on every state change.
  assign restart = (state_n != state) || (state == S_IDLE) || (state == S_DONE);

  // NOTE: every variable written here gets its default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    unique case (state)
      S_IDLE:  if (bus.status == ST_TRANSMIT && !done_q) state_n = S_FETCH;
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        shreg_n = bus.mem_rdata;
        state_n = S_START;
      end
      S_START: if (bit_tick) state_n = S_DATA;
      S_DATA: if (bit_tick) begin
        shreg_n   = shreg >> 1;
        bit_cnt_n = bit_cnt + BIT_W'(1);
        if (bit_cnt == LAST_BIT) state_n = S_STOP;
      end
      S_STOP: if (bit_tick) begin
        if (byte_cnt == LAST_BYTE) begin
          state_n = S_DONE;
        end else begin
          byte_cnt_n = byte_cnt + BYTE_W'(1);
          state_n    = S_FETCH;
        end
      end
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase

    // Serial line and flags are registered from the next state so tx never glitches.
    unique case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  assign bus.mem_re           = (state == S_FETCH);
  assign bus.mem_addr         = byte_cnt[ADDR_W-1:0];
  assign bus.tx               = tx_q;
  assign bus.busy             = busy_q;
  assign bus.end_transmitting = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Self-checking bench for uart_tx_controller: a 3-byte instance and a 1-byte instance,
// checked cycle by cycle against a frame-arithmetic model of the expected line waveform.
module tb_uart_tx_controller;
  import uart_tx_controller_pkg::*;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int FRAME = 2 + 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_lows;

  logic [7:0] mem0 [0:15];
  logic [7:0] mem1 [0:15];

  uart_tx_controller_if #(.ADDR_W(AW)) bus0 ();
  uart_tx_controller_if #(.ADDR_W(AW)) bus1 ();

  uart_tx_controller #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .NUM_BYTES(3)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  uart_tx_controller #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .NUM_BYTES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Data memories: read data valid the cycle after the strobe.
  always @(posedge clk) if (bus0.mem_re) bus0.mem_rdata <= mem0[bus0.mem_addr];
  always @(posedge clk) if (bus1.mem_re) bus1.mem_rdata <= mem1[bus1.mem_addr];

  typedef struct {
    int         n;
    logic       tx;
    logic       busy;
    logic       re;
    logic [3:0] addr;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_status(input int which, input logic [1:0] v);
    if (which == 0) bus0.status = v;
    else            bus1.status = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus0.status = ST_RECEIVE;
    bus1.status = ST_RECEIVE;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Expected {tx, busy, mem_re, end_transmitting} at sample n (n=1 is the cycle after
  // the arming edge), derived from frame layout: 2 fetch cycles, start, 8 data, stop.
  function automatic logic [3:0] model(input int n, input int nb, input int which);
    int         k   = (n - 1) / FRAME;
    int         off = (n - 1) % FRAME;
    logic [7:0] b;
    logic       t;
    if (k >= nb) return 4'b1001;
    b = (which == 0) ? mem0[k] : mem1[k];
    if (off < 2)                t = 1'b1;
    else if (off < 2 + CPB)     t = 1'b0;
    else if (off < 2 + 9 * CPB) t = b[(off - 2 - CPB) / CPB];
    else                        t = 1'b1;
    return {t, 1'b1, (off == 0), 1'b0};
  endfunction

  task automatic run_check(input int which, input int nb, input int total, input int drop_at,
                           input logic [1:0] drop_val, input int rst_at, input bit rnd);
    logic [3:0] got, exp;
    logic [3:0] addr;
    int         lows = 0;
    set_status(which, ST_TRANSMIT);
    for (int n = 1; n <= total; n++) begin
      @(posedge clk);
      #1;
      if (which == 0) begin
        got  = {bus0.tx, bus0.busy, bus0.mem_re, bus0.end_transmitting};
        addr = bus0.mem_addr;
      end else begin
        got  = {bus1.tx, bus1.busy, bus1.mem_re, bus1.end_transmitting};
        addr = bus1.mem_addr;
      end
      exp = model(n, nb, which);
      check($sformatf("dut%0d n=%0d {tx,busy,re,end}", which, n), got, exp);
      if (exp[1]) check($sformatf("dut%0d n=%0d mem_addr", which, n), addr, (n - 1) / FRAME);
      if (!got[3]) lows++;
      if (n == drop_at) set_status(which, drop_val);
      if (rnd) set_status(which, 2'($urandom_range(0, 3)));
      if (n == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check($sformatf("dut%0d async reset {tx,busy,re}", which),
              (which == 0) ? {bus0.tx, bus0.busy, bus0.mem_re} : {bus1.tx, bus1.busy, bus1.mem_re},
              3'b100);
        last_lows = lows;
        return;
      end
    end
    last_lows = lows;
  endtask

  initial begin
    vecs[0]  = '{1,  1'b1, 1'b1, 1'b1, 4'd0};
    vecs[1]  = '{2,  1'b1, 1'b1, 1'b0, 4'd0};
    vecs[2]  = '{3,  1'b0, 1'b1, 1'b0, 4'd0};
    vecs[3]  = '{6,  1'b0, 1'b1, 1'b0, 4'd0};
    vecs[4]  = '{7,  1'b1, 1'b1, 1'b0, 4'd0};
    vecs[5]  = '{10, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[6]  = '{11, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[7]  = '{15, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[8]  = '{19, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[9]  = '{23, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[10] = '{27, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[11] = '{31, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[12] = '{35, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[13] = '{39, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[14] = '{42, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[15] = '{43, 1'b1, 1'b1, 1'b1, 4'd1};

    for (int i = 0; i < 16; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[0] = 8'hA5;
    mem0[1] = 8'h3C;
    mem0[2] = 8'hFF;
    bus0.mem_rdata = 8'h00;
    bus1.mem_rdata = 8'h00;
    do_reset();

    // Idle in receive phase: nothing moves on either instance.
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle c=%0d dut0", c),
            {bus0.tx, bus0.busy, bus0.mem_re, bus0.end_transmitting}, 4'b1000);
      check($sformatf("idle c=%0d dut1", c),
            {bus1.tx, bus1.busy, bus1.mem_re, bus1.end_transmitting}, 4'b1000);
    end

    // First frame (0xA5) against the hand-written vector table.
    begin
      int n = 0;
      bus0.status = ST_TRANSMIT;
      for (int i = 0; i < 16; i++) begin
        while (n < vecs[i].n) begin
          @(posedge clk);
          #1;
          n++;
        end
        check($sformatf("vec n=%0d {tx,busy,re}", vecs[i].n),
              {bus0.tx, bus0.busy, bus0.mem_re}, {vecs[i].tx, vecs[i].busy, vecs[i].re});
        if (vecs[i].re) check($sformatf("vec n=%0d mem_addr", vecs[i].n), bus0.mem_addr, vecs[i].addr);
      end
    end
    do_reset();

    // Full three-byte run, then completion must survive the sequencer moving on.
    run_check(0, 3, 3 * FRAME + 1, -1, ST_RECEIVE, -1, 1'b0);
    foreach (vecs[i]) begin
      if (i < 3) begin
        set_status(0, (i == 0) ? ST_TRANSMIT : (i == 1) ? ST_ALLDONE : ST_RECEIVE);
        repeat (3) begin
          @(posedge clk);
          #1;
          check($sformatf("done hold step=%0d {tx,busy,re,end}", i),
                {bus0.tx, bus0.busy, bus0.mem_re, bus0.end_transmitting}, 4'b1001);
        end
      end
    end
    do_reset();

    // Status leaves transmit during byte 1 data bits: run still completes.
    run_check(0, 3, 3 * FRAME + 4, FRAME + 10, ST_PROCESS, -1, 1'b0);
    do_reset();

    // Reset during byte 2 data bits, then re-arm from address 0.
    run_check(0, 3, 3 * FRAME, -1, ST_RECEIVE, 2 * FRAME + 10, 1'b0);
    do_reset();
    run_check(0, 3, 3 * FRAME + 4, -1, ST_RECEIVE, -1, 1'b0);
    do_reset();

    // Random data with random status noise after the start.
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) mem0[j] = 8'($urandom);
      run_check(0, 3, 3 * FRAME + 3, -1, ST_RECEIVE, -1, 1'b1);
      do_reset();
    end

    // Single-byte instance sending 0x00: 36 low cycles, then stop and done.
    run_check(1, 1, FRAME + 6, -1, ST_RECEIVE, -1, 1'b0);
    check("dut1 low cycles", last_lows, 36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
